lpddr5_timing_ctrl: RTL

- Sits between `lpddr5_controller` and the PHY model.
- Takes one DRAM command at a time from the controller's `dram_*` port and holds it until per-bank and global JEDEC spacing constraints are met. It then issues the command to the PHY for exactly one cycle and waits the command's completion latency before returning a one-cycle `dram_ready`.
- Tracks open banks, rejects illegal sequences, and inserts an automatic precharge-all before refresh.

---
 rtl/lpddr5_params.sv | 42 ++++
 rtl/lpddr5_bank_timer.sv | 41 ++++
 rtl/lpddr5_timing_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lpddr5_params.sv
// Shared types, widths and default JEDEC timing for the LPDDR5 timing controller.
package lpddr5_params;

  localparam int unsigned CHANNELS     = 2;
  localparam int unsigned BURST_LENGTH = 16;
  localparam int unsigned DATA_BITS    = 32;
  localparam int unsigned ADDR_WIDTH   = 16;
  localparam int unsigned BANK_NUM     = 8;
  localparam int unsigned BANK_BITS    = $clog2(BANK_NUM);
  localparam int unsigned WAIT_WIDTH   = 8;
  localparam int unsigned LAT_WIDTH    = 9;

  localparam int unsigned DEF_T_RCD = 8;
  localparam int unsigned DEF_T_RP  = 8;
  localparam int unsigned DEF_T_RAS = 17;
  localparam int unsigned DEF_T_RRD = 4;
  localparam int unsigned DEF_T_RFC = 28;
  localparam int unsigned DEF_T_WR  = 14;
  localparam int unsigned DEF_T_RTP = 4;
  localparam int unsigned DEF_RL    = 10;
  localparam int unsigned DEF_WL    = 6;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } dram_cmd_t;

  typedef enum logic [2:0] {
    TC_IDLE = 3'd0,
    TC_HOLD = 3'd1,
    TC_PREA = 3'd2,
    TC_BUSY = 3'd3,
    TC_DONE = 3'd4
  } tc_state_t;

  typedef logic [CHANNELS-1:0][BURST_LENGTH-1:0][DATA_BITS-1:0] burst_t;

endpackage

// File: rtl/lpddr5_bank_timer.sv
// One bank: open flag plus the earliest-precharge countdown.
module lpddr5_bank_timer
  import lpddr5_params::*;
#(
  parameter int unsigned T_RAS = DEF_T_RAS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  act_set,
  input  logic                  pre_clr,
  input  logic                  max_ld,
  input  logic [WAIT_WIDTH-1:0] max_val,
  output logic                  bank_open,
  output logic [WAIT_WIDTH-1:0] pre_wait
);

  // Open flag: set by ACT, cleared by PRE or PRE-all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= 1'b0;
    end else if (act_set) begin
      bank_open <= 1'b1;
    end else if (pre_clr) begin
      bank_open <= 1'b0;
    end
  end

  // Precharge wait: loads win over the saturating decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_wait <= '0;
    end else if (act_set) begin
      pre_wait <= WAIT_WIDTH'(T_RAS);
    end else if (max_ld) begin
      pre_wait <= (max_val > pre_wait) ? max_val : pre_wait;
    end else if (pre_wait != '0) begin
      pre_wait <= pre_wait - WAIT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lpddr5_timing_ctrl.sv
// Holds one controller command until bank/global spacing allows, issues it, then times completion.
module lpddr5_timing_ctrl
  import lpddr5_params::*;
#(
  parameter int unsigned T_RCD = DEF_T_RCD,
  parameter int unsigned T_RP  = DEF_T_RP,
  parameter int unsigned T_RAS = DEF_T_RAS,
  parameter int unsigned T_RRD = DEF_T_RRD,
  parameter int unsigned T_RFC = DEF_T_RFC,
  parameter int unsigned T_WR  = DEF_T_WR,
  parameter int unsigned T_RTP = DEF_T_RTP,
  parameter int unsigned RL    = DEF_RL,
  parameter int unsigned WL    = DEF_WL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  dram_cmd_t             dram_cmd,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  burst_t                dram_wdata,
  output burst_t                dram_rdata,
  output logic                  dram_ready,
  output dram_cmd_t             phy_cmd,
  output logic [ADDR_WIDTH-1:0] phy_addr,
  output burst_t                phy_wdata,
  input  burst_t                phy_rdata,
  output logic                  proto_err
);

  tc_state_t             state;
  dram_cmd_t             cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LAT_WIDTH-1:0]  lat_cnt;
  logic [WAIT_WIDTH-1:0] rrd_cnt;
  logic                  prea_sent;

  logic [BANK_NUM-1:0]   bank_open;
  logic [WAIT_WIDTH-1:0] pre_wait [BANK_NUM];

  logic [BANK_BITS-1:0]  bank_c;
  logic                  legal_c, can_issue_c, any_open_c, prea_ready_c;
  logic                  issue_c, prea_issue_c, wr_done_c;
  logic [BANK_NUM-1:0]   act_set_c, pre_clr_c, max_ld_c;
  logic [WAIT_WIDTH-1:0] max_val_c;

  function automatic logic [LAT_WIDTH-1:0] lat_of(dram_cmd_t c);
    case (c)
      CMD_ACT: return LAT_WIDTH'(T_RCD);
      CMD_PRE: return LAT_WIDTH'(T_RP);
      CMD_REF: return LAT_WIDTH'(T_RFC);
      CMD_RD:  return LAT_WIDTH'(RL + BURST_LENGTH / 2);
      CMD_WR:  return LAT_WIDTH'(WL + BURST_LENGTH / 2);
      default: return LAT_WIDTH'(1);
    endcase
  endfunction

  // Legality, issue readiness and per-bank timer controls for the held command.
  always_comb begin
    bank_c       = addr_q[ADDR_WIDTH-1 -: BANK_BITS];
    any_open_c   = |bank_open;
    prea_ready_c = 1'b1;
    legal_c      = 1'b1;
    can_issue_c  = 1'b0;
    act_set_c    = '0;
    pre_clr_c    = '0;
    max_ld_c     = '0;
    for (int i = 0; i < int'(BANK_NUM); i++) begin
      if (bank_open[i] && (pre_wait[i] != '0)) prea_ready_c = 1'b0;
    end
    case (cmd_q)
      CMD_ACT: begin
        legal_c     = !bank_open[bank_c];
        can_issue_c = (rrd_cnt == '0);
      end
      CMD_PRE: begin
        legal_c     = bank_open[bank_c];
        can_issue_c = (pre_wait[bank_c] == '0);
      end
      CMD_RD, CMD_WR: begin
        legal_c     = bank_open[bank_c];
        can_issue_c = 1'b1;
      end
      CMD_REF: can_issue_c = !any_open_c;
      default: can_issue_c = 1'b0;
    endcase
    issue_c      = (state == TC_HOLD) && legal_c && can_issue_c;
    prea_issue_c = (state == TC_PREA) && !prea_sent && prea_ready_c;
    wr_done_c    = (state == TC_BUSY) && (lat_cnt == '0) && (cmd_q == CMD_WR);
    max_val_c    = (cmd_q == CMD_RD) ? WAIT_WIDTH'(T_RTP) : WAIT_WIDTH'(T_WR);
    for (int i = 0; i < int'(BANK_NUM); i++) begin
      if (bank_c == BANK_BITS'(i)) begin
        act_set_c[i] = issue_c && (cmd_q == CMD_ACT);
        pre_clr_c[i] = issue_c && (cmd_q == CMD_PRE);
        max_ld_c[i]  = (issue_c && (cmd_q == CMD_RD)) || wr_done_c;
      end
      if (prea_issue_c) pre_clr_c[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < int'(BANK_NUM); g++) begin : g_bank
    lpddr5_bank_timer #(.T_RAS(T_RAS)) u_bank_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .act_set   (act_set_c[g]),
      .pre_clr   (pre_clr_c[g]),
      .max_ld    (max_ld_c[g]),
      .max_val   (max_val_c),
      .bank_open (bank_open[g]),
      .pre_wait  (pre_wait[g])
    );
  end

  // ACT-to-ACT spacing across all banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
    end else if (issue_c && (cmd_q == CMD_ACT)) begin
      rrd_cnt <= WAIT_WIDTH'(T_RRD);
    end else if (rrd_cnt != '0) begin
      rrd_cnt <= rrd_cnt - WAIT_WIDTH'(1);
    end
  end

  // Command sequencer with registered PHY and controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TC_IDLE;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      lat_cnt    <= '0;
      prea_sent  <= 1'b0;
      phy_cmd    <= CMD_NOP;
      phy_addr   <= '0;
      phy_wdata  <= '0;
      dram_rdata <= '0;
      dram_ready <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      phy_cmd    <= CMD_NOP;
      dram_ready <= 1'b0;
      proto_err  <= 1'b0;
      case (state)
        TC_IDLE: begin
          if (dram_cmd != CMD_NOP) begin
            cmd_q     <= dram_cmd;
            addr_q    <= dram_addr;
            phy_wdata <= dram_wdata;
            state     <= TC_HOLD;
          end
        end
        TC_HOLD: begin
          if (!legal_c) begin
            dram_ready <= 1'b1;
            proto_err  <= 1'b1;
            state      <= TC_DONE;
          end else if ((cmd_q == CMD_REF) && any_open_c) begin
            prea_sent <= 1'b0;
            state     <= TC_PREA;
          end else if (can_issue_c) begin
            phy_cmd  <= cmd_q;
            phy_addr <= addr_q;
            lat_cnt  <= lat_of(cmd_q) - LAT_WIDTH'(1);
            state    <= TC_BUSY;
          end
        end
        TC_PREA: begin
          if (!prea_sent) begin
            if (prea_ready_c) begin
              phy_cmd   <= CMD_PRE;
              phy_addr  <= '1;
              lat_cnt   <= LAT_WIDTH'(T_RP - 1);
              prea_sent <= 1'b1;
            end
          end else if (lat_cnt == '0) begin
            state <= TC_HOLD;
          end else begin
            lat_cnt <= lat_cnt - LAT_WIDTH'(1);
          end
        end
        TC_BUSY: begin
          if (lat_cnt == '0) begin
            dram_ready <= 1'b1;
            if (cmd_q == CMD_RD) dram_rdata <= phy_rdata;
            state <= TC_DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_WIDTH'(1);
          end
        end
        TC_DONE: state <= TC_IDLE;
        default: state <= TC_IDLE;
      endcase
    end
  end

endmodule
